sccb_responder: RTL and testbench
=================================

// Module: sccb_responder
// PURPOSE
//  SCCB target (camera-side) model. Oversamples SIO_C/SIO_D from the on-chip SCCB master, decodes
//  3-phase writes and 2-phase write+read transactions, and holds a 256x8 register file.
//  It is the far end of the master's bus in the loopback test design. It stands in for the
//  camera so the master can be tested without a sensor.
//  Requirement: clk >= 20x SIO_C frequency (10 MHz vs 100 kHz nominal).
// PARAMETERS
//  DEV_ID       7'h21  7-bit device ID. Write ID byte = {DEV_ID,0} = 8'h42; read ID byte = 8'h43.
//  SYNC_STAGES  2      Synchronizer flops on sioc_in and siod_in (min 2).
// PORTS
//  clk         in   1  System clock.
//  resetn      in   1  Asynchronous, active-low reset.
//  sioc_in     in   1  SIO_C pin level. Driven by the master.
//  siod_in     in   1  SIO_D pin level (bus wired value).
//  siod_out    out  1  SIO_D drive value. Valid only when siod_oe=1.
//  siod_oe     out  1  1 = drive siod_out onto SIO_D. 0 = release the bus.
//  wr_strobe   out  1  One-clk pulse when a register is written.
//  wr_addr     out  8  Sub-address of the completed write. Held until the next write.
//  wr_data     out  8  Data of the completed write. Held until the next write.
//  busy        out  1  1 from START until STOP. Otherwise 0.
//  dbg_addr    in   8  Debug read address.
//  dbg_data    out  8  Combinational regfile[dbg_addr].
// BEHAVIOUR
//  Reset: FSM=IDLE, siod_oe=0, siod_out=1, wr_strobe=0, wr_addr=0, wr_data=0, busy=0,
//   sub-address pointer=0, all regfile entries=8'h00.
//   A reset during a transaction aborts it; no partial write reaches the regfile.
//  Sync/edges: sioc_s and siod_s are sioc_in and siod_in after SYNC_STAGES flops.
//   Edge flags come from one further register, so a pin change is seen SYNC_STAGES+1 clk later.
//  Bus conditions:
//   START = siod_s falls while sioc_s=1. STOP = siod_s rises while sioc_s=1.
//   START in any state (repeated start) -> ID, bit count=0, siod_oe=0.
//   STOP in any state -> IDLE, siod_oe=0.
//   START/STOP take priority over a sioc edge in the same clk.
//  Bits are MSB first. Data is sampled on a sioc_s rising edge. The responder's SIO_D drive
//   changes only on a sioc_s falling edge. Every 9th bit is the X/NA phase.
//  FSM states: IDLE, ID, ID_X, SUB, SUB_X, WDAT, WDAT_X, RDAT, RDAT_NA, WAIT_STOP.
//   ID     8 bits shifted.
//          ID[7:1]!=DEV_ID -> WAIT_STOP (responder never drives).
//          Match with R/W=0 -> ID_X then SUB.
//          Match with R/W=1 -> ID_X then RDAT.
//   SUB    8 bits are latched into the pointer -> SUB_X -> WDAT.
//          STOP here is a 2-phase write: only the pointer is updated.
//   WDAT   8 bits -> on the rising edge of bit 8: regfile[ptr]<=byte, wr_addr=ptr, wr_data=byte,
//          wr_strobe=1 for 1 clk. Then WDAT_X -> WAIT_STOP (no auto-increment;
//          extra bytes are ignored and never driven).
//   RDAT   On the falling edge ending ID_X: load regfile[ptr], siod_oe=1, siod_out=MSB.
//          Each later falling edge shifts out the next bit. After the falling edge following
//          bit 0: siod_oe=0 -> RDAT_NA. The NA bit is sampled and ignored -> WAIT_STOP.
//          ptr is unchanged.
//   WAIT_STOP  Bus released; only waits for STOP or START.
//  busy=1 in every state except IDLE.
//  A write and a dbg read of the same address in the same clk return the old value.
//   The new value is visible the next clk.
// CONFIGURATION
//  SCCB_RESP_ACK_EN defined: during ID_X (ID matched), SUB_X and WDAT_X, the responder drives
//   siod_oe=1, siod_out=0 from the falling edge that opens the X bit to the falling edge
//   that closes it (I2C-style ACK). RDAT_NA is still released.
//  SCCB_RESP_ACK_EN undefined: siod_oe=0 for all X bits (pure SCCB "don't care").
// TESTING
//  1 Reset mid-WDAT (resetn=0 for 2 clk) -> all outputs at reset values, regfile[0x12] stays
//    8'h00, no wr_strobe.
//  2 Write 42/12/80 + STOP -> exactly one wr_strobe with wr_addr=8'h12 and wr_data=8'h80;
//    dbg_addr=8'h12 gives dbg_data=8'h80; busy returns to 0 after STOP.
//  3 Write 42/0A + STOP, then 43 + read -> master samples 8'h76 when regfile[0x0A]=8'h76 was
//    preloaded by a prior write; siod_oe=0 during NA and after STOP.
//  4 ID 8'h60 + 2 bytes -> siod_oe stays 0 throughout, no wr_strobe, busy=1 until STOP.
//  5 Repeated START after 42/12 -> no write occurs; the new 42/13/55 writes regfile[0x13]=8'h55.
//  6 With SCCB_RESP_ACK_EN: siod_out=0 and siod_oe=1 at every sioc_s rising edge of the 3 X bits
//    in test 2. Without it: siod_oe=0 at those edges.

Source files
------------

// File: rtl/sccb_responder_if.sv
// SCCB pin bundle plus write-notify and debug-read signals between a master-side driver and the responder.
interface sccb_responder_if;
    logic       sioc_in;
    logic       siod_in;
    logic       siod_out;
    logic       siod_oe;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [7:0] dbg_addr;
    logic [7:0] dbg_data;

    modport slave (
        input  sioc_in, siod_in, dbg_addr,
        output siod_out, siod_oe, wr_strobe, wr_addr, wr_data, busy, dbg_data
    );

    modport master (
        output sioc_in, siod_in, dbg_addr,
        input  siod_out, siod_oe, wr_strobe, wr_addr, wr_data, busy, dbg_data
    );
endinterface

// File: rtl/sccb_responder.sv
// SCCB camera-side target with a 256x8 register file; optional ACK drive on X bits via SCCB_RESP_ACK_EN.
// Latency: pin change acted on SYNC_STAGES+1 clk later; write strobe on the rising edge of the data byte's last bit.
// Backpressure: none, the responder never stretches SIO_C; it only follows the master's timing.
module sccb_responder #(
    parameter logic [6:0] DEV_ID      = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    sccb_responder_if.slave   bus
);

    typedef enum logic [3:0] {
        IDLE, ID, ID_X, SUB, SUB_X, WDAT, WDAT_X, RDAT, RDAT_NA, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] sioc_sync;
    logic [SYNC_STAGES-1:0] siod_sync;
    logic                   sioc_d;
    logic                   siod_d;
    logic                   sioc_s;
    logic                   siod_s;
    logic                   sioc_rise;
    logic                   sioc_fall;
    logic                   start_cond;
    logic                   stop_cond;

    state_t     state;
    logic [7:0] regfile [256];
    logic [7:0] sr;
    logic [7:0] rx_byte;
    logic [7:0] ptr;
    logic [3:0] cnt;
    logic       x_rise;
    logic       rw;
    logic       siod_out_q;
    logic       siod_oe_q;
    logic       wr_strobe_q;
    logic [7:0] wr_addr_q;
    logic [7:0] wr_data_q;

    assign sioc_s     = sioc_sync[SYNC_STAGES-1];
    assign siod_s     = siod_sync[SYNC_STAGES-1];
    assign sioc_rise  = sioc_s & ~sioc_d;
    assign sioc_fall  = ~sioc_s & sioc_d;
    assign start_cond = sioc_s & siod_d & ~siod_s;
    assign stop_cond  = sioc_s & ~siod_d & siod_s;
    assign rx_byte    = {sr[6:0], siod_s};

    // Synchronizers reset to the idle-high bus level so reset release is not seen as an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sioc_sync <= '1;
            siod_sync <= '1;
            sioc_d    <= 1'b1;
            siod_d    <= 1'b1;
        end else begin
            sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], bus.sioc_in};
            siod_sync <= {siod_sync[SYNC_STAGES-2:0], bus.siod_in};
            sioc_d    <= sioc_s;
            siod_d    <= siod_s;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            sr          <= '0;
            ptr         <= '0;
            cnt         <= '0;
            x_rise      <= 1'b0;
            rw          <= 1'b0;
            siod_out_q  <= 1'b1;
            siod_oe_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int i = 0; i < 256; i++) regfile[i] <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (start_cond) begin
                state      <= ID;
                cnt        <= '0;
                siod_oe_q  <= 1'b0;
                siod_out_q <= 1'b1;
            end else if (stop_cond) begin
                state      <= IDLE;
                siod_oe_q  <= 1'b0;
                siod_out_q <= 1'b1;
            end else if (sioc_rise) begin
                case (state)
                    ID, SUB, WDAT: begin
                        sr  <= rx_byte;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt    <= '0;
                            x_rise <= 1'b0;
                            if (state == ID) begin
                                if (rx_byte[7:1] != DEV_ID) begin
                                    state <= WAIT_STOP;
                                end else begin
                                    rw    <= rx_byte[0];
                                    state <= ID_X;
                                end
                            end else if (state == SUB) begin
                                ptr   <= rx_byte;
                                state <= SUB_X;
                            end else begin
                                regfile[ptr] <= rx_byte;
                                wr_addr_q    <= ptr;
                                wr_data_q    <= rx_byte;
                                wr_strobe_q  <= 1'b1;
                                state        <= WDAT_X;
                            end
                        end
                    end
                    ID_X, SUB_X, WDAT_X: x_rise <= 1'b1;
                    RDAT:                cnt    <= cnt + 4'd1;
                    RDAT_NA:             state  <= WAIT_STOP;
                    default: ;
                endcase
            end else if (sioc_fall) begin
                case (state)
                    ID_X, SUB_X, WDAT_X: begin
                        if (!x_rise) begin
`ifdef SCCB_RESP_ACK_EN
                            siod_oe_q  <= 1'b1;
                            siod_out_q <= 1'b0;
`else
                            siod_oe_q  <= 1'b0;
`endif
                        end else begin
                            siod_oe_q  <= 1'b0;
                            siod_out_q <= 1'b1;
                            cnt        <= '0;
                            if (state == ID_X && rw) begin
                                // MSB goes out now; sr holds the remaining bits left-aligned
                                sr         <= {regfile[ptr][6:0], 1'b0};
                                siod_out_q <= regfile[ptr][7];
                                siod_oe_q  <= 1'b1;
                                state      <= RDAT;
                            end else if (state == ID_X) begin
                                state <= SUB;
                            end else if (state == SUB_X) begin
                                state <= WDAT;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    RDAT: begin
                        if (cnt == 4'd8) begin
                            siod_oe_q  <= 1'b0;
                            siod_out_q <= 1'b1;
                            state      <= RDAT_NA;
                        end else begin
                            siod_out_q <= sr[7];
                            sr         <= {sr[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.siod_out  = siod_out_q;
    assign bus.siod_oe   = siod_oe_q;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = (state != IDLE);
    assign bus.dbg_data  = regfile[bus.dbg_addr];

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: bit-banged SCCB master, directed corner cases, a vector table and random traffic vs a transaction model.
module tb_sccb_responder;
    localparam int Q = 6;   // clk per quarter SIO_C period (24 clk per bit)

`ifdef SCCB_RESP_ACK_EN
    localparam logic ACK = 1'b1;
`else
    localparam logic ACK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] dbg_a = 8'h00;

    always #5 clk = ~clk;

    sccb_responder_if bus ();
    assign bus.sioc_in  = m_scl;
    assign bus.siod_in  = m_sda & (bus.siod_oe ? bus.siod_out : 1'b1);
    assign bus.dbg_addr = dbg_a;

    sccb_responder dut (.clk(clk), .resetn(resetn), .bus(bus));

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int oe_cnt = 0;

    always @(negedge clk) begin
        if (bus.wr_strobe) strobe_cnt++;
        if (bus.siod_oe)   oe_cnt++;
    end

    logic [7:0] ref_mem [256];
    logic [7:0] ref_ptr = 8'h00;

    typedef struct {
        logic [7:0] id, sub, dat;
        int         exp_strobes;
        logic [7:0] exp_addr, exp_data, exp_dbg;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start;
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic m_stop;
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic m_bit(input logic b, output logic rd, output logic oe);
        m_sda = b;    wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        rd = bus.siod_in;
        oe = bus.siod_oe;
        wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    // Eight data bits then the X/NA bit with the master releasing SIO_D.
    task automatic m_byte(input logic [7:0] b, output logic [7:0] rd, output logic x_oe, output logic x_rd);
        logic r, o;
        for (int i = 7; i >= 0; i--) begin
            m_bit(b[i], r, o);
            rd[i] = r;
        end
        m_bit(1'b1, x_rd, x_oe);
    endtask

    // Transaction model: matching write ID moves the pointer; a third byte stores into it.
    task automatic do_write(input logic [7:0] id, sub, dat, output logic [2:0] xoe, output logic [2:0] xrd);
        logic [7:0] rd;
        m_start;
        m_byte(id,  rd, xoe[2], xrd[2]);
        m_byte(sub, rd, xoe[1], xrd[1]);
        m_byte(dat, rd, xoe[0], xrd[0]);
        m_stop;
        if (id == 8'h42) begin
            ref_ptr      = sub;
            ref_mem[sub] = dat;
        end
    endtask

    task automatic do_setptr(input logic [7:0] sub);
        logic [7:0] rd;
        logic       a, b;
        m_start;
        m_byte(8'h42, rd, a, b);
        m_byte(sub,   rd, a, b);
        m_stop;
        ref_ptr = sub;
    endtask

    task automatic do_read(output logic [7:0] data, output logic na_oe);
        logic [7:0] rd;
        logic       a, b;
        m_start;
        m_byte(8'h43, rd, a, b);
        m_byte(8'hFF, data, na_oe, b);
        m_stop;
    endtask

    initial begin : main
        logic [7:0] rd, sub, dat;
        logic [2:0] xoe, xrd;
        logic       a, b, na;
        int         s0, o0;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        vecs[0] = '{8'h42, 8'h20, 8'hA5, 1, 8'h20, 8'hA5, 8'hA5};
        vecs[1] = '{8'h42, 8'hFF, 8'h01, 1, 8'hFF, 8'h01, 8'h01};
        vecs[2] = '{8'h42, 8'h00, 8'hFE, 1, 8'h00, 8'hFE, 8'hFE};
        vecs[3] = '{8'h44, 8'h21, 8'h33, 0, 8'h00, 8'hFE, 8'h00};
        vecs[4] = '{8'h84, 8'h22, 8'h44, 0, 8'h00, 8'hFE, 8'h00};
        vecs[5] = '{8'h42, 8'h20, 8'h5A, 1, 8'h20, 8'h5A, 8'h5A};

        // Reset values
        dbg_a = 8'h12;
        wait_clk(3);
        chk("rst_oe", bus.siod_oe, 0);
        chk("rst_out", bus.siod_out, 1);
        chk("rst_strobe", bus.wr_strobe, 0);
        chk("rst_addr", bus.wr_addr, 0);
        chk("rst_data", bus.wr_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dbg", bus.dbg_data, 0);
        resetn = 1'b1;
        wait_clk(5);

        // Reset in the middle of the data byte aborts the write
        s0 = strobe_cnt;
        m_start;
        m_byte(8'h42, rd, a, b);
        m_byte(8'h12, rd, a, b);
        m_bit(1'b1, a, b); m_bit(1'b0, a, b); m_bit(1'b0, a, b); m_bit(1'b0, a, b);
        chk("midwr_busy", bus.busy, 1);
        resetn = 1'b0; wait_clk(2);
        resetn = 1'b1; wait_clk(1);
        chk("midwr_oe", bus.siod_oe, 0);
        chk("midwr_out", bus.siod_out, 1);
        chk("midwr_busy0", bus.busy, 0);
        chk("midwr_addr", bus.wr_addr, 0);
        chk("midwr_data", bus.wr_data, 0);
        chk("midwr_dbg", bus.dbg_data, 0);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(2 * Q);
        chk("midwr_nostrobe", strobe_cnt - s0, 0);

        // Plain 3-phase write, including X-bit drive
        s0 = strobe_cnt;
        m_start;
        chk("wr_busy_start", bus.busy, 1);
        m_byte(8'h42, rd, xoe[2], xrd[2]);
        m_byte(8'h12, rd, xoe[1], xrd[1]);
        m_byte(8'h80, rd, xoe[0], xrd[0]);
        chk("wr_busy_prestop", bus.busy, 1);
        m_stop;
        ref_ptr = 8'h12; ref_mem[8'h12] = 8'h80;
        wait_clk(4);
        chk("wr_strobes", strobe_cnt - s0, 1);
        chk("wr_addr", bus.wr_addr, 8'h12);
        chk("wr_data", bus.wr_data, 8'h80);
        chk("wr_dbg", bus.dbg_data, 8'h80);
        chk("wr_busy_stop", bus.busy, 0);
        chk("x_oe", xoe, {3{ACK}});
        chk("x_bus", xrd, {3{~ACK}});

        // Preload, 2-phase pointer set, then read
        do_write(8'h42, 8'h0A, 8'h76, xoe, xrd);
        s0 = strobe_cnt;
        do_setptr(8'h0A);
        chk("ptr_nostrobe", strobe_cnt - s0, 0);
        do_read(rd, na);
        wait_clk(4);
        chk("rd_data", rd, 8'h76);
        chk("rd_na_oe", na, 0);
        chk("rd_oe_after_stop", bus.siod_oe, 0);
        chk("rd_busy", bus.busy, 0);

        // Foreign device ID: never driven, no write
        s0 = strobe_cnt; o0 = oe_cnt;
        m_start;
        m_byte(8'h60, rd, xoe[2], xrd[2]);
        m_byte(8'h12, rd, xoe[1], xrd[1]);
        m_byte(8'h34, rd, xoe[0], xrd[0]);
        chk("nid_busy", bus.busy, 1);
        m_stop;
        wait_clk(4);
        chk("nid_oe_never", oe_cnt - o0, 0);
        chk("nid_strobes", strobe_cnt - s0, 0);
        chk("nid_busy_stop", bus.busy, 0);
        chk("nid_dbg", bus.dbg_data, 8'h80);

        // Repeated START after the sub-address abandons that write
        s0 = strobe_cnt;
        m_start;
        m_byte(8'h42, rd, a, b);
        m_byte(8'h12, rd, a, b);
        do_write(8'h42, 8'h13, 8'h55, xoe, xrd);
        wait_clk(2);
        chk("rs_strobes", strobe_cnt - s0, 1);
        chk("rs_addr", bus.wr_addr, 8'h13);
        dbg_a = 8'h12; wait_clk(1);
        chk("rs_old_reg", bus.dbg_data, 8'h80);
        dbg_a = 8'h13; wait_clk(1);
        chk("rs_new_reg", bus.dbg_data, 8'h55);

        // Vector table
        for (int v = 0; v < 6; v++) begin
            s0 = strobe_cnt;
            do_write(vecs[v].id, vecs[v].sub, vecs[v].dat, xoe, xrd);
            dbg_a = vecs[v].sub;
            wait_clk(2);
            chk($sformatf("vec%0d_strobes", v), strobe_cnt - s0, vecs[v].exp_strobes);
            chk($sformatf("vec%0d_addr", v), bus.wr_addr, vecs[v].exp_addr);
            chk($sformatf("vec%0d_data", v), bus.wr_data, vecs[v].exp_data);
            chk($sformatf("vec%0d_dbg", v), bus.dbg_data, vecs[v].exp_dbg);
        end

        // Random traffic vs the transaction model
        for (int n = 0; n < 24; n++) begin
            sub = 8'($urandom_range(0, 7));
            dat = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: begin
                    s0 = strobe_cnt;
                    do_write(8'h42, sub, dat, xoe, xrd);
                    wait_clk(2);
                    chk($sformatf("rnd%0d_strobes", n), strobe_cnt - s0, 1);
                    chk($sformatf("rnd%0d_addr", n), bus.wr_addr, sub);
                    chk($sformatf("rnd%0d_data", n), bus.wr_data, dat);
                end
                1: begin
                    do_setptr(sub);
                    do_read(rd, na);
                    chk($sformatf("rnd%0d_rd", n), rd, ref_mem[sub]);
                end
                default: begin
                    do_read(rd, na);
                    chk($sformatf("rnd%0d_rdptr", n), rd, ref_mem[ref_ptr]);
                end
            endcase
        end
        for (int i = 0; i < 8; i++) begin
            dbg_a = 8'(i);
            wait_clk(1);
            chk($sformatf("final_reg%0d", i), bus.dbg_data, ref_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
